// File: rtl/mat_row_mem_server_if.sv
// Bus bundle for the row memory server: two read clients, one writer and the clear control.
// "slave" is the memory side and "master" is the client side.
interface mat_row_mem_server_if #(
  parameter int SIZE  = 32,
  parameter int WIDTH = 64,
  parameter int ROW_W = SIZE * 2 * WIDTH,
  parameter int AW    = $clog2(SIZE)
);
  logic [AW-1:0]    rd0_addr_i;
  logic             rd0_addr_valid_i;
  logic             rd0_addr_ready_o;
  logic [ROW_W-1:0] rd0_row_o;
  logic [AW-1:0]    rd0_addr_o;
  logic             rd0_valid_o;
  logic [AW-1:0]    rd1_addr_i;
  logic             rd1_addr_valid_i;
  logic             rd1_addr_ready_o;
  logic [ROW_W-1:0] rd1_row_o;
  logic [AW-1:0]    rd1_addr_o;
  logic             rd1_valid_o;
  logic [ROW_W-1:0] wr_row_i;
  logic [AW-1:0]    wr_addr_i;
  logic             wr_valid_i;
  logic             wr_ready_o;
  logic             clear_i;
  logic             busy_o;

  modport slave (
    input  rd0_addr_i, rd0_addr_valid_i, rd1_addr_i, rd1_addr_valid_i,
    input  wr_row_i, wr_addr_i, wr_valid_i, clear_i,
    output rd0_addr_ready_o, rd0_row_o, rd0_addr_o, rd0_valid_o,
    output rd1_addr_ready_o, rd1_row_o, rd1_addr_o, rd1_valid_o,
    output wr_ready_o, busy_o
  );

  modport master (
    output rd0_addr_i, rd0_addr_valid_i, rd1_addr_i, rd1_addr_valid_i,
    output wr_row_i, wr_addr_i, wr_valid_i, clear_i,
    input  rd0_addr_ready_o, rd0_row_o, rd0_addr_o, rd0_valid_o,
    input  rd1_addr_ready_o, rd1_row_o, rd1_addr_o, rd1_valid_o,
    input  wr_ready_o, busy_o
  );
endinterface

// File: rtl/mat_row_mem_server.sv
// Row-oriented matrix store: two round-robin read clients with 1-cycle registered
// responses, one row write per cycle, and a sequential clear engine.
module mat_row_mem_server #(
  parameter int SIZE  = 32,
  parameter int WIDTH = 64,
  parameter int ROW_W = SIZE * 2 * WIDTH,
  parameter int AW    = $clog2(SIZE)
) (
  input logic                  clk_i,
  input logic                  rst_i,
  mat_row_mem_server_if.slave  bus
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

  localparam logic [AW:0]   SIZE_L = (AW + 1)'(SIZE);
  localparam logic [AW-1:0] LAST_L = AW'(SIZE - 1);

  logic [ROW_W-1:0] mem_q [SIZE];

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic             ptr_q;
  logic             busy_q;
  logic [ROW_W-1:0] rd0_row_q, rd1_row_q;
  logic [AW-1:0]    rd0_addr_q, rd1_addr_q;
  logic             rd0_valid_q, rd1_valid_q;

  logic             idle_s, req0_s, req1_s, gnt0_s, gnt1_s;
  logic             wr_fire_s, wr_in_range_s, rd_in_range_s;
  logic [AW-1:0]    rd_addr_s;
  logic [ROW_W-1:0] rd_data_s;

  always_comb begin
    idle_s        = (state_q == ST_IDLE);
    req0_s        = bus.rd0_addr_valid_i & idle_s;
    req1_s        = bus.rd1_addr_valid_i & idle_s;
    // ptr_q==0 gives client 0 priority when both clients request
    gnt0_s        = req0_s & (~req1_s | ~ptr_q);
    gnt1_s        = req1_s & (~req0_s | ptr_q);
    rd_addr_s     = gnt1_s ? bus.rd1_addr_i : bus.rd0_addr_i;
    wr_fire_s     = bus.wr_valid_i & idle_s;
    wr_in_range_s = ({1'b0, bus.wr_addr_i} < SIZE_L);
    rd_in_range_s = ({1'b0, rd_addr_s} < SIZE_L);
    if (!rd_in_range_s) begin
      rd_data_s = '0;
    end else if (wr_fire_s && wr_in_range_s && (bus.wr_addr_i == rd_addr_s)) begin
      rd_data_s = bus.wr_row_i;
    end else begin
      rd_data_s = mem_q[rd_addr_s];
    end
  end

  assign bus.rd0_addr_ready_o = gnt0_s;
  assign bus.rd1_addr_ready_o = gnt1_s;
  assign bus.wr_ready_o       = idle_s;
  assign bus.busy_o           = busy_q;
  assign bus.rd0_row_o        = rd0_row_q;
  assign bus.rd0_addr_o       = rd0_addr_q;
  assign bus.rd0_valid_o      = rd0_valid_q;
  assign bus.rd1_row_o        = rd1_row_q;
  assign bus.rd1_addr_o       = rd1_addr_q;
  assign bus.rd1_valid_o      = rd1_valid_q;

  // Storage has no reset; gating on rst_i lets a reset abort a clear mid-sweep.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (wr_fire_s && wr_in_range_s) begin
        mem_q[bus.wr_addr_i] <= bus.wr_row_i;
      end else if (state_q == ST_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      busy_q      <= 1'b0;
      rd0_row_q   <= '0;
      rd0_addr_q  <= '0;
      rd0_valid_q <= 1'b0;
      rd1_row_q   <= '0;
      rd1_addr_q  <= '0;
      rd1_valid_q <= 1'b0;
    end else begin
      rd0_valid_q <= gnt0_s;
      rd1_valid_q <= gnt1_s;
      if (gnt0_s) begin
        rd0_row_q  <= rd_data_s;
        rd0_addr_q <= bus.rd0_addr_i;
      end
      if (gnt1_s) begin
        rd1_row_q  <= rd_data_s;
        rd1_addr_q <= bus.rd1_addr_i;
      end
      if (req0_s && req1_s) begin
        ptr_q <= gnt0_s;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.clear_i) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == LAST_L) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_row_mem_server.sv
// Directed bench for mat_row_mem_server with SIZE=4: reset, read latency, arbitration,
// write bypass, clear engine, reset mid-clear and back-to-back reads.
module tb_mat_row_mem_server;
  localparam int SIZE  = 4;
  localparam int WIDTH = 64;
  localparam int ROW_W = SIZE * 2 * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  mat_row_mem_server_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();
  mat_row_mem_server #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] pat(input logic [7:0] s);
    return {64{s}};
  endfunction

  task automatic write_row(input logic [1:0] a, input logic [ROW_W-1:0] d);
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = a;
    bus.wr_row_i   = d;
    tick();
    bus.wr_valid_i = 1'b0;
  endtask

  // Client 0 reads rows 0..3 on consecutive cycles; each response lands one cycle after its grant.
  task automatic read_all(input string tag, input logic [ROW_W-1:0] e0, input logic [ROW_W-1:0] e1,
                          input logic [ROW_W-1:0] e2, input logic [ROW_W-1:0] e3);
    logic [ROW_W-1:0] exp_a [4];
    exp_a[0] = e0; exp_a[1] = e1; exp_a[2] = e2; exp_a[3] = e3;
    bus.rd0_addr_valid_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus.rd0_addr_i = 2'(j);
      tick();
      chk({tag, "_valid"}, ROW_W'(bus.rd0_valid_o), ROW_W'(1'b1));
      chk({tag, "_addr"}, ROW_W'(bus.rd0_addr_o), ROW_W'(j));
      chk({tag, "_row"}, bus.rd0_row_o, exp_a[j]);
    end
    bus.rd0_addr_valid_i = 1'b0;
    tick();
    chk({tag, "_idle"}, ROW_W'(bus.rd0_valid_o), ROW_W'(1'b0));
  endtask

  logic [ROW_W-1:0] r3;
  logic [ROW_W-1:0] pa, pb;

  initial begin
    r3 = {4{64'h0000000000000000, 64'h4008000000000000}};
    pa = pat(8'hA5);
    pb = pat(8'hB6);
    bus.rd0_addr_i = 2'd0; bus.rd0_addr_valid_i = 1'b0;
    bus.rd1_addr_i = 2'd0; bus.rd1_addr_valid_i = 1'b0;
    bus.wr_row_i = '0; bus.wr_addr_i = 2'd0; bus.wr_valid_i = 1'b0; bus.clear_i = 1'b0;
    tick(); tick();
    chk("rst_rd0_valid", ROW_W'(bus.rd0_valid_o), ROW_W'(1'b0));
    chk("rst_rd0_row", bus.rd0_row_o, '0);
    chk("rst_rd1_addr", ROW_W'(bus.rd1_addr_o), ROW_W'(2'd0));
    chk("rst_busy", ROW_W'(bus.busy_o), ROW_W'(1'b0));
    rst = 1'b0;
    #1;
    chk("idle_wr_ready", ROW_W'(bus.wr_ready_o), ROW_W'(1'b1));

    // Single read with 1-cycle latency
    write_row(2'd2, r3);
    bus.rd0_addr_valid_i = 1'b1; bus.rd0_addr_i = 2'd2;
    #1;
    chk("t1_ready0", ROW_W'(bus.rd0_addr_ready_o), ROW_W'(1'b1));
    tick();
    bus.rd0_addr_valid_i = 1'b0;
    chk("t1_valid0", ROW_W'(bus.rd0_valid_o), ROW_W'(1'b1));
    chk("t1_addr0", ROW_W'(bus.rd0_addr_o), ROW_W'(2'd2));
    chk("t1_row0", bus.rd0_row_o, r3);
    chk("t1_valid1", ROW_W'(bus.rd1_valid_o), ROW_W'(1'b0));
    tick();
    chk("t1_valid_drop", ROW_W'(bus.rd0_valid_o), ROW_W'(1'b0));
    chk("t1_row_hold", bus.rd0_row_o, r3);

    // Contended arbitration after reset
    write_row(2'd1, pat(8'h11));
    write_row(2'd3, pat(8'h33));
    rst = 1'b1; tick(); rst = 1'b0;
    bus.rd0_addr_valid_i = 1'b1; bus.rd0_addr_i = 2'd1;
    bus.rd1_addr_valid_i = 1'b1; bus.rd1_addr_i = 2'd3;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("arb_ready0", ROW_W'(bus.rd0_addr_ready_o), ROW_W'(i % 2 == 0));
      chk("arb_ready1", ROW_W'(bus.rd1_addr_ready_o), ROW_W'(i % 2 == 1));
      tick();
      chk("arb_valid0", ROW_W'(bus.rd0_valid_o), ROW_W'(i % 2 == 0));
      chk("arb_valid1", ROW_W'(bus.rd1_valid_o), ROW_W'(i % 2 == 1));
      if (i % 2 == 0) begin
        chk("arb_addr0", ROW_W'(bus.rd0_addr_o), ROW_W'(2'd1));
        chk("arb_row0", bus.rd0_row_o, pat(8'h11));
      end else begin
        chk("arb_addr1", ROW_W'(bus.rd1_addr_o), ROW_W'(2'd3));
        chk("arb_row1", bus.rd1_row_o, pat(8'h33));
      end
    end
    bus.rd0_addr_valid_i = 1'b0; bus.rd1_addr_valid_i = 1'b0;

    // Same-cycle write/read of row 0 returns the new data
    write_row(2'd0, pb);
    bus.wr_valid_i = 1'b1; bus.wr_addr_i = 2'd0; bus.wr_row_i = pa;
    bus.rd1_addr_valid_i = 1'b1; bus.rd1_addr_i = 2'd0;
    tick();
    bus.wr_valid_i = 1'b0; bus.rd1_addr_valid_i = 1'b0;
    chk("byp_valid1", ROW_W'(bus.rd1_valid_o), ROW_W'(1'b1));
    chk("byp_row1", bus.rd1_row_o, pa);

    // Clear after filling every row
    for (int i = 0; i < 4; i++) write_row(2'(i), pat(8'(8'h40 + i)));
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    bus.rd0_addr_valid_i = 1'b1; bus.rd0_addr_i = 2'd0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("clr_busy", ROW_W'(bus.busy_o), ROW_W'(1'b1));
      chk("clr_wr_ready", ROW_W'(bus.wr_ready_o), ROW_W'(1'b0));
      chk("clr_rd_ready", ROW_W'(bus.rd0_addr_ready_o), ROW_W'(1'b0));
      tick();
    end
    chk("clr_done_busy", ROW_W'(bus.busy_o), ROW_W'(1'b0));
    chk("clr_done_ready", ROW_W'(bus.rd0_addr_ready_o), ROW_W'(1'b1));
    read_all("clr_rd", '0, '0, '0, '0);

    // Reset aborting a clear during its third cycle
    for (int i = 0; i < 4; i++) write_row(2'(i), pat(8'(8'h70 + i)));
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    tick(); tick();
    chk("abort_busy_before", ROW_W'(bus.busy_o), ROW_W'(1'b1));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_busy", ROW_W'(bus.busy_o), ROW_W'(1'b0));
    read_all("abort_rd", '0, '0, pat(8'h72), pat(8'h73));

    // Reset kills a read granted on the same edge
    bus.rd1_addr_valid_i = 1'b1; bus.rd1_addr_i = 2'd3;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.rd1_addr_valid_i = 1'b0;
    chk("kill_valid1", ROW_W'(bus.rd1_valid_o), ROW_W'(1'b0));
    chk("kill_row1", bus.rd1_row_o, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mat_row_mem_server.md
Name: mat_row_mem_server

Overview:
- Row-oriented matrix memory that answers the row read/write protocol issued by the matrix compute engines (LU decomposition, triangular inverse).
- Serves two independent read clients through a round-robin arbiter, with fixed 1-cycle registered read latency and echoed address.
- Accepts one row write per cycle.
- Provides a sequential clear engine that zeroes the store between factorisation passes.

Parameters:
SIZE, 32, number of rows; also the number of complex elements per row
WIDTH, 64, bits per real/imag component (IEEE double)
ROW_W, SIZE*2*WIDTH, bits per row; element j = {imag,real} at [j*2*WIDTH +: 2*WIDTH]
AW, $clog2(SIZE), row address width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
rd0_addr_i  in  AW  client 0 read row address
rd0_addr_valid_i  in  1  client 0 read request
rd0_addr_ready_o  out  1  client 0 request granted this cycle
rd0_row_o  out  ROW_W  client 0 read data
rd0_addr_o  out  AW  echoed address of rd0_row_o
rd0_valid_o  out  1  client 0 response valid (single cycle)
rd1_addr_i  in  AW  client 1 read row address
rd1_addr_valid_i  in  1  client 1 read request
rd1_addr_ready_o  out  1  client 1 grant
rd1_row_o  out  ROW_W  client 1 read data
rd1_addr_o  out  AW  echoed address
rd1_valid_o  out  1  client 1 response valid
wr_row_i  in  ROW_W  write row data
wr_addr_i  in  AW  write row address
wr_valid_i  in  1  write request
wr_ready_o  out  1  write accepted when wr_valid_i&wr_ready_o
clear_i  in  1  pulse: zero all rows
busy_o  out  1  clear in progress

Behaviour:
- Reset (rst_i=1 at posedge):
  - all outputs 0: rd*_row_o, rd*_addr_o, rd*_valid_o, busy_o.
  - FSM=IDLE, arbiter pointer=client 0, clear counter=0.
  - Memory array contents are not reset.
- FSM states:
  - IDLE: wr_ready_o=1; grants allowed.
  - CLEAR: entered on clear_i=1 in IDLE; busy_o=1 from the next cycle.
    - Writes zero to row cnt each cycle, cnt 0..SIZE-1, then returns to IDLE: exactly SIZE cycles in CLEAR.
    - In CLEAR: wr_ready_o=0, rd*_addr_ready_o=0.
    - clear_i is ignored while in CLEAR.
    - Responses already in flight still complete.
- Read grants (IDLE only, combinational):
  - Only one read port to the array; at most one grant per cycle.
  - One client valid: that client granted.
  - Both valid: the client indicated by the pointer is granted; the pointer then moves to the other client.
  - The pointer only updates on a contended grant.
  - A non-granted client holds its request; the address must stay stable until ready.
- Read response:
  - A grant at edge t gives rdX_valid_o=1 during cycle t+1 with rdX_row_o = mem[addr] and rdX_addr_o = addr.
  - valid is low otherwise. Data and addr hold their last value when valid is low.
  - No response back-pressure; the client must sink every response.
- Write:
  - When wr_valid_i&wr_ready_o, mem[wr_addr_i] <= wr_row_i at the edge.
- Read and write to the same address in the same cycle: write-first; the response carries wr_row_i (bypass).
- clear_i and wr_valid_i in the same IDLE cycle: the write is accepted (wr_ready_o=1 in IDLE), then CLEAR starts, so the row ends zero.
- Addresses ≥ SIZE (SIZE not a power of 2):
  - write ignored;
  - read granted, responds with all-zero row.
- Reset mid-CLEAR aborts to IDLE; rows not yet cleared keep old contents.
- Reset kills any in-flight response: valid=0 next cycle.

Test Plan:
- SIZE=4:
  - write row2 = all elements (3.0+j0), then client0 reads addr 2 → next cycle rd0_valid_o=1, rd0_addr_o=2, data matches.
  - rd1_valid_o stays 0.
- Both clients request each cycle, client0 addr1, client1 addr3, for 4 cycles after reset → grants alternate 0,1,0,1.
  - Responses return one cycle after each grant with the correct echoed addresses.
- Same-cycle write addr0 = pattern A and client1 read addr0 (old = B) → response data = A.
- clear_i pulse after filling all rows:
  - busy_o high for exactly 4 cycles;
  - ready signals low during CLEAR;
  - subsequent reads of rows 0..3 return 0.
- Assert rst_i at cycle 2 of CLEAR → busy_o=0 next cycle.
  - Rows 0–1 read 0; rows 2–3 read their pre-clear data.
- Back-to-back single-client reads addr 0,1,2,3 on consecutive cycles → four consecutive valid responses, 1-cycle latency, in order.
